// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, NOP constant and byte-lane helper for the instruction memory loader.
package imem_pkg;
  typedef enum logic [2:0] {BOOT, LEN, DATA, RUN, ERR} state_e;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  function automatic logic [31:0] lane_insert(input logic [31:0] w, input logic [1:0] lane, input logic [7:0] b);
    logic [4:0] sh;
    sh = {lane, 3'b000};
    return (w & ~(32'h000000FF << sh)) | ({24'b0, b} << sh);
  endfunction
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four little-endian handshaked bytes into a word with a one-cycle word_valid pulse.
module byte_packer import imem_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        hs_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;
  // The completed word is presented combinationally so the consumer can act on the 4th handshake edge.
  assign word_o       = lane_insert(word_q, byte_cnt_q, data_i);
  assign word_valid_o = hs_i && (byte_cnt_q == 2'd3);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (clr_i) begin
      byte_cnt_q <= '0;
    end else if (hs_i) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      word_q     <= word_o;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-loaded instruction memory with combinational fetch and a byte-stream loader FSM.
module imem_loader import imem_pkg::*; #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSN    = imem_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  output logic        addr_misaligned,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_err,
  output logic        cpu_hold
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  state_e             state_q, state_d;
  logic [31:0]        len_q, len_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W:0]     loaded_q, loaded_d;
  logic               err_q, err_d;
  logic               we, start_ok, hs, word_valid;
  logic [31:0]        word;
  logic [31:0]        mem [DEPTH_WORDS];
  logic [IDX_W-1:0]   idx;
  assign ld_ready        = (state_q == LEN) || (state_q == DATA);
  assign ld_done         = state_q == RUN;
  assign cpu_hold        = state_q != RUN;
  assign ld_err          = err_q;
  assign hs              = ld_valid && ld_ready;
  assign start_ok        = ld_start && !ld_ready;
  assign idx             = address[IDX_W+1:2];
  assign addr_misaligned = address[1:0] != 2'b00;
  assign instruction     = (ld_done && address[31:IDX_W+2] == '0 && {1'b0, idx} < loaded_q) ? mem[idx] : NOP_INSN;
  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .hs_i         (hs),
    .data_i       (ld_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    we       = 1'b0;
    if (start_ok) begin
      state_d  = LEN;
      ptr_d    = '0;
      loaded_d = '0;
      err_d    = 1'b0;
    end else if (word_valid && state_q == LEN) begin
      len_d   = word;
      err_d   = word > 32'(DEPTH_WORDS);
      state_d = (word == '0) ? RUN : (word > 32'(DEPTH_WORDS)) ? ERR : DATA;
    end else if (word_valid && state_q == DATA) begin
      we       = 1'b1;
      ptr_d    = ptr_q + 1'b1;
      loaded_d = loaded_q + 1'b1;
      state_d  = (32'(loaded_q) + 32'd1 == len_q) ? RUN : DATA;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      len_q    <= '0;
      ptr_q    <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end
  // Storage is deliberately unreset; loaded_q gates every read instead.
  always_ff @(posedge clk) begin
    if (we) mem[ptr_q] <= word;
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed load/fetch scenarios checked every cycle against a stream-level model.
module tb_imem_loader;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address = '0;
  logic [31:0] instruction;
  logic        addr_misaligned, ld_ready, ld_done, ld_err, cpu_hold;
  logic        ld_start = 1'b0, ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  int vectors = 0, miscompares = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .address(address), .instruction(instruction),
    .addr_misaligned(addr_misaligned), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // Model: tracks the loader only as "collecting length", "collecting program", "running", "error", "idle".
  bit          m_collect_len = 0, m_collect_prog = 0, m_running = 0, m_err = 0;
  int          m_nbytes = 0, m_nloaded = 0;
  longint      m_len = 0;
  int          m_buf [4];
  logic [31:0] m_mem [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_collect_len = 0; m_collect_prog = 0; m_running = 0; m_err = 0;
      m_nbytes = 0; m_nloaded = 0; m_len = 0;
    end else if (ld_start && !(m_collect_len || m_collect_prog)) begin
      m_collect_len = 1; m_collect_prog = 0; m_running = 0; m_err = 0;
      m_nbytes = 0; m_nloaded = 0;
    end else if (ld_valid && (m_collect_len || m_collect_prog)) begin
      m_buf[m_nbytes] = int'(ld_data);
      m_nbytes++;
      if (m_nbytes == 4) begin
        longint w;
        w = m_buf[0] + m_buf[1] * 256 + m_buf[2] * 65536 + longint'(m_buf[3]) * 16777216;
        m_nbytes = 0;
        if (m_collect_len) begin
          m_len = w;
          m_collect_len = 0;
          if (w == 0) m_running = 1;
          else if (w > 256) m_err = 1;
          else m_collect_prog = 1;
        end else begin
          m_mem[m_nloaded] = w[31:0];
          m_nloaded++;
          if (m_nloaded == m_len) begin
            m_collect_prog = 0;
            m_running = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_insn;
    exp_insn = (m_running && address < 32'd1024 && int'(address / 4) < m_nloaded) ? m_mem[address / 4] : NOP;
    chk("insn", instruction, exp_insn);
    chk("misaligned", 32'(addr_misaligned), 32'(address % 4 != 0));
    chk("ready", 32'(ld_ready), 32'(m_collect_len || m_collect_prog));
    chk("done", 32'(ld_done), 32'(m_running));
    chk("hold", 32'(cpu_hold), 32'(!m_running));
    chk("err", 32'(ld_err), 32'(m_err));
  end

  task automatic start_load();
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = ld_ready;
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] prog5 [5] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};

  initial begin
    rst = 1'b1;
    idle(3);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_insn0", instruction, 32'h00000013);
    rst = 1'b0;
    idle(2);
    chk("boot_hold", 32'(cpu_hold), 32'd1);

    // N=2 load, bytes back to back
    start_load();
    send_word(32'd2);
    send_word(32'h00500093);
    send_word(32'h00A00113);
    chk("n2_done", 32'(ld_done), 32'd1);
    chk("n2_hold", 32'(cpu_hold), 32'd0);
    address = 32'd0; #1 chk("n2_a0", instruction, 32'h00500093);
    address = 32'd4; #1 chk("n2_a4", instruction, 32'h00A00113);
    address = 32'd8; #1 chk("n2_a8", instruction, 32'h00000013);
    address = 32'd0;
    idle(2);

    // Same stream with a 3-cycle gap in the middle of a word
    start_load();
    send_word(32'd2);
    send_byte(8'h93); send_byte(8'h00);
    idle(3);
    send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h13); idle(3); send_byte(8'h01); send_byte(8'hA0); send_byte(8'h00);
    chk("gap_done", 32'(ld_done), 32'd1);
    address = 32'd0; #1 chk("gap_a0", instruction, 32'h00500093);
    address = 32'd4; #1 chk("gap_a4", instruction, 32'h00A00113);
    address = 32'd8; #1 chk("gap_a8", instruction, 32'h00000013);
    address = 32'd0;
    idle(2);

    // Oversized length, then empty program
    start_load();
    send_word(32'h00000101);
    chk("ovf_err", 32'(ld_err), 32'd1);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    chk("ovf_ready", 32'(ld_ready), 32'd0);
    chk("ovf_insn", instruction, 32'h00000013);
    idle(2);
    start_load();
    chk("restart_err", 32'(ld_err), 32'd0);
    send_word(32'd0);
    chk("n0_err", 32'(ld_err), 32'd0);
    chk("n0_done", 32'(ld_done), 32'd1);
    chk("n0_insn", instruction, 32'h00000013);
    idle(2);

    // Reset after five bytes of a load
    start_load();
    send_word(32'd5);
    send_byte(8'hAA);
    #2 rst = 1'b1;
    #1 chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_ready", 32'(ld_ready), 32'd0);
    chk("mid_rst_insn", instruction, 32'h00000013);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Fresh 5-word load and PC-driven fetch
    start_load();
    send_word(32'd5);
    for (int i = 0; i < 5; i++) send_word(prog5[i]);
    chk("n5_done", 32'(ld_done), 32'd1);
    address = 32'd0;
    for (int i = 0; i < 8; i++) begin
      #1 chk("pc_step", instruction, (i < 5) ? prog5[i] : 32'h00000013);
      @(posedge clk); #1;
      address = address + 32'd4;
    end
    address = 32'h6; #1
    chk("mis_flag", 32'(addr_misaligned), 32'd1);
    chk("mis_insn", instruction, 32'h00200113);
    address = 32'h00001000; #1
    chk("far_insn", instruction, 32'h00000013);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-side responder to the program counter: takes the PC `address` and returns the 32-bit instruction combinationally, as the monocycle datapath requires.
- Holds its own word array, filled at boot by a byte-stream loader that uses a valid/ready handshake.
- Asserts `cpu_hold` while a program is being loaded, so the core does not fetch stale or partial code.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored.
- IDX_W, $clog2(DEPTH_WORDS), word index width. Derived; not overridden.
- NOP_INSN, 32'h00000013, value returned for unloaded, out-of-range or held fetches (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  32  byte address from the PC.
- instruction  out  32  fetched instruction word, combinational.
- addr_misaligned  out  1  high when address[1:0] != 0; combinational.
- ld_start  in  1  single-cycle pulse that begins a program load.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_ready  out  1  loader byte accepted when ld_valid && ld_ready.
- ld_done  out  1  high in RUN state.
- ld_err  out  1  sticky error: declared length exceeds DEPTH_WORDS.
- cpu_hold  out  1  high whenever the state is not RUN; the core holds its PC while this is high.

Behaviour:
- States:
  - BOOT: entered on reset; waits for ld_start.
  - LEN: collects 4 length bytes.
  - DATA: collects 4*N program bytes.
  - RUN
  - ERR
- Reset (async, rst=1):
  - state=BOOT, byte_cnt=0, word_ptr=0, loaded_words=0, len_reg=0, ld_err=0.
  - Outputs during reset: ld_ready=0, ld_done=0, cpu_hold=1.
  - The memory array is not reset. loaded_words=0 makes every fetch return NOP_INSN.
- Transitions:
  - BOOT/RUN/ERR -> LEN on ld_start. This clears loaded_words, word_ptr, byte_cnt and ld_err.
  - ld_start while in LEN or DATA is ignored.
- Byte assembly:
  - Little-endian; byte_cnt (2 bits) selects the lane: byte 0 -> bits [7:0], byte 3 -> bits [31:24].
  - byte_cnt advances only on a handshake and wraps 3 -> 0.
- LEN: on the 4th handshake, len_reg = the assembled word.
  - len_reg == 0 -> RUN next cycle.
  - len_reg > DEPTH_WORDS -> ERR, with ld_err=1.
  - Otherwise -> DATA.
- DATA:
  - On the 4th handshake of each word: write mem[word_ptr] = the assembled word, then word_ptr++ and loaded_words++.
  - When loaded_words reaches len_reg, move to RUN on that same edge.
- ld_ready: high in LEN and DATA, low otherwise. It has no dependence on ld_valid.
- Gaps: ld_valid may drop between bytes, and the partial word is kept.
- ERR: cpu_hold=1 and ld_ready=0 until the next ld_start.
- Fetch (combinational), with idx = address[IDX_W+1:2]:
  - instruction = mem[idx] only when state==RUN, address[31:IDX_W+2]==0 and idx < loaded_words.
  - Otherwise instruction = NOP_INSN.
  - Misaligned addresses still fetch the word at the truncated address, with addr_misaligned=1.
- Read-during-write: the fetch returns the old content. This is irrelevant in practice because cpu_hold is high whenever writes occur.
- Reset mid-load: all progress is discarded and previously loaded words become unreachable (loaded_words=0).

Decomposition:
- Package imem_pkg:
  - state enum: BOOT, LEN, DATA, RUN, ERR.
  - NOP_INSN constant.
  - Helper function for the little-endian byte-lane insert.
- Sub-module byte_packer: 4-byte to word assembler, containing byte_cnt, the shift/lane register and a word_valid pulse.
- The FSM, storage and fetch logic stay in imem_loader.

Test Plan:
- Reset, no load -> cpu_hold=1, ld_done=0; address=0 gives instruction=32'h00000013.
- Load N=2:
  - Stimulus: bytes 02 00 00 00, 93 00 50 00, 13 01 A0 00.
  - Response: ld_done=1 and cpu_hold=0 on the edge after the last byte.
  - address=0 -> 32'h00500093, address=4 -> 32'h00A00113, address=8 -> NOP.
- Loader gaps: same stream with ld_valid deasserted for 3 cycles mid-word -> identical memory contents; no byte is dropped or duplicated.
- Length DEPTH_WORDS+1 (32'h00000101) -> ld_err=1, state ERR, cpu_hold=1, ld_ready=0. A following ld_start with N=0 -> ld_err=0, ld_done=1.
- rst pulsed after 5 bytes of a load -> immediately cpu_hold=1, ld_ready=0; every fetch returns NOP; a fresh load succeeds.
- PC-driven fetch after loading 5 words:
  - Stepping address 0,4,8,... (next_pc = address+4) returns the words in order, then NOP for address>=20.
  - address=32'h6 gives addr_misaligned=1 and the instruction of word 1.
  - address=32'h00001000 gives NOP.
